// File: rtl/ps2_frame_receiver_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM encoding, frame size and default tuning.
package ps2_frame_receiver_pkg;

  localparam int unsigned PS2_FRAME_BITS         = 11;
  localparam int unsigned DEFAULT_FILTER_LEN     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;
  localparam int unsigned PS2_DATA_BITS          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_line_filter.sv
// Two-flop synchronizer plus stability filter for one raw PS/2 line, with a registered
// falling-edge pulse aligned to the cycle the filtered level drops.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic qzt_clk,
  input  logic nreset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_fall;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = (r_sync[1] != r_level);
  // The FILTER_LEN-th consecutive differing sample commits the new level
  assign w_flip = w_diff && (r_cnt == CNT_W'(FILTER_LEN - 1));

  always_ff @(posedge qzt_clk or negedge nreset) begin
    if (!nreset) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= w_flip && r_level;
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_flip) begin
        r_level <= r_sync[1];
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: filters both lines, shifts 11-bit frames on
// ps2_clk falling edges, checks odd parity and stop bit, and flags timeouts.
module ps2_frame_receiver
  import ps2_frame_receiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       qzt_clk,
  input  logic       nreset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       edge_tick
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SHIFT_W = PS2_FRAME_BITS - 1;
  localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 2);

  state_t             r_state,     w_state_n;
  logic [3:0]         r_bit_cnt,   w_bit_cnt_n;
  logic [TMO_W-1:0]   r_tmo,       w_tmo_n;
  logic [SHIFT_W-1:0] r_shift,     w_shift_n;
  logic [7:0]         r_dout,      w_dout_n;
  logic               r_valid,     w_valid_n;
  logic               r_perr,      w_perr_n;
  logic               r_ferr,      w_ferr_n;
  logic               r_busy,      w_busy_n;
  logic               r_pend,      w_pend_n;
  logic               r_pend_data, w_pend_data_n;

  logic w_clk_fall;
  logic w_unused_clk_level;
  logic w_data_level;
  logic w_unused_data_fall;
  logic w_idle_edge;
  logic w_idle_bit;
  logic w_parity_ok;
  logic w_stop_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .qzt_clk (qzt_clk),
    .nreset  (nreset),
    .i_line  (ps2_clk),
    .o_level (w_unused_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .qzt_clk (qzt_clk),
    .nreset  (nreset),
    .i_line  (ps2_data),
    .o_level (w_data_level),
    .o_fall  (w_unused_data_fall)
  );

  // An edge seen during CHECK is replayed in IDLE with the data level captured then
  assign w_idle_edge = w_clk_fall || r_pend;
  assign w_idle_bit  = r_pend ? r_pend_data : w_data_level;
  assign w_parity_ok = odd_parity_ok(r_shift[PS2_DATA_BITS:0]);
  assign w_stop_ok   = r_shift[SHIFT_W-1];

  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_tmo_n       = r_tmo;
    w_shift_n     = r_shift;
    w_dout_n      = r_dout;
    w_valid_n     = 1'b0;
    w_perr_n      = 1'b0;
    w_ferr_n      = 1'b0;
    w_pend_n      = 1'b0;
    w_pend_data_n = r_pend_data;
    case (r_state)
      ST_IDLE: begin
        w_bit_cnt_n = '0;
        w_tmo_n     = '0;
        if (w_idle_edge) begin
          if (!w_idle_bit) begin
            w_state_n = ST_RECV;
            w_shift_n = '0;
          end else begin
            w_ferr_n = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (w_clk_fall) begin
          w_shift_n = {w_data_level, r_shift[SHIFT_W-1:1]};
          w_tmo_n   = '0;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_n = ST_CHECK;
          end else begin
            w_bit_cnt_n = r_bit_cnt + 4'd1;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_n   = ST_IDLE;
          w_ferr_n    = 1'b1;
          w_tmo_n     = '0;
          w_bit_cnt_n = '0;
          w_shift_n   = '0;
        end else begin
          w_tmo_n = r_tmo + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        w_state_n     = ST_IDLE;
        w_pend_n      = w_clk_fall;
        w_pend_data_n = w_data_level;
        if (w_parity_ok && w_stop_ok) begin
          w_dout_n  = r_shift[PS2_DATA_BITS-1:0];
          w_valid_n = 1'b1;
        end else begin
          w_perr_n = !w_parity_ok;
          w_ferr_n = !w_stop_ok;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    w_busy_n = (w_state_n != ST_IDLE);
  end

  always_ff @(posedge qzt_clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_tmo       <= '0;
      r_shift     <= '0;
      r_dout      <= 8'h00;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_data <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_tmo       <= w_tmo_n;
      r_shift     <= w_shift_n;
      r_dout      <= w_dout_n;
      r_valid     <= w_valid_n;
      r_perr      <= w_perr_n;
      r_ferr      <= w_ferr_n;
      r_busy      <= w_busy_n;
      r_pend      <= w_pend_n;
      r_pend_data <= w_pend_data_n;
    end
  end

  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;
  assign edge_tick  = w_clk_fall;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed and randomized PS/2 frames checked against a frame-level reference model.
module tb_ps2_frame_receiver;

  localparam int unsigned FLEN  = 8;
  localparam int unsigned TMO   = 400;
  localparam int          HALF  = 40;
  localparam int          SETUP = 20;

  logic       qzt_clk  = 1'b0;
  logic       nreset   = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       edge_tick;

  ps2_frame_receiver #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .qzt_clk    (qzt_clk),
    .nreset     (nreset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .edge_tick  (edge_tick)
  );

  always #5 qzt_clk = ~qzt_clk;

  int checks = 0;
  int errors = 0;

  // Cumulative pulse counters; frames compare deltas
  int cyc = 0, n_edge = 0, n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
  int last_edge_cyc = 0, valid_lat = -1;

  always @(negedge qzt_clk) begin
    cyc++;
    if (edge_tick) begin
      n_edge++;
      last_edge_cyc = cyc;
    end
    if (data_valid) begin
      n_valid++;
      valid_lat = cyc - last_edge_cyc;
    end
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (data_valid && (parity_err || frame_err)) n_overlap++;
  end

  logic [7:0] model_dout = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge qzt_clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic p;
    p = (~^b) ^ par_bad;
    return {~stop_bad, p, b, 1'b0};
  endfunction

  // Device-side waveform: data changes mid-high, clock low for HALF cycles per bit
  task automatic drive_frame(input logic [10:0] bits, input int n_bits, input bit glitch);
    for (int i = 0; i < n_bits; i++) begin
      ps2_data = bits[i];
      wait_cyc(SETUP / 2);
      if (glitch) begin
        ps2_clk = 1'b0;
        wait_cyc(1);
        ps2_clk = 1'b1;
      end
      wait_cyc(SETUP / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF / 2);
      if (glitch) begin
        ps2_clk = 1'b1;
        wait_cyc(1);
        ps2_clk = 1'b0;
      end
      wait_cyc(HALF / 2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - SETUP);
    end
    ps2_data = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit par_bad,
                           input bit stop_bad, input bit glitch);
    int e0, v0, p0, f0, o0;
    bit exp_valid;
    e0 = n_edge; v0 = n_valid; p0 = n_perr; f0 = n_ferr; o0 = n_overlap;
    drive_frame(mk_frame(b, par_bad, stop_bad), 11, glitch);
    wait_cyc(20);
    exp_valid = !par_bad && !stop_bad;
    if (exp_valid) model_dout = b;
    chk({tag, "_edges"},   n_edge - e0,    11);
    chk({tag, "_valid"},   n_valid - v0,   exp_valid ? 1 : 0);
    chk({tag, "_perr"},    n_perr - p0,    par_bad ? 1 : 0);
    chk({tag, "_ferr"},    n_ferr - f0,    stop_bad ? 1 : 0);
    chk({tag, "_overlap"}, n_overlap - o0, 0);
    chk({tag, "_dout"},    data_out,       model_dout);
    chk({tag, "_busy"},    busy,           0);
    if (exp_valid) chk({tag, "_latency"}, valid_lat, 2);
  endtask

  initial begin
    int e0, v0, p0, f0;
    logic [7:0] rb;
    int r;
    #2 nreset = 1'b0;
    wait_cyc(5);
    chk("rst_dout",  data_out,   8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_perr",  parity_err, 0);
    chk("rst_ferr",  frame_err,  0);
    chk("rst_busy",  busy,       0);
    chk("rst_edge",  edge_tick,  0);
    nreset = 1'b1;
    wait_cyc(20);
    chk("idle_no_edge", n_edge, 0);

    run_frame("fa",  8'hFA, 1'b0, 1'b0, 1'b0);
    run_frame("p08", 8'h08, 1'b1, 1'b0, 1'b0);
    run_frame("s55", 8'h55, 1'b0, 1'b1, 1'b0);

    // Stall after start bit plus four data bits until the timeout fires
    e0 = n_edge; v0 = n_valid; f0 = n_ferr;
    drive_frame(mk_frame(8'h12, 1'b0, 1'b0), 5, 1'b0);
    chk("tmo_busy_mid", busy, 1);
    wait_cyc(TMO + 100);
    chk("tmo_edges", n_edge - e0, 5);
    chk("tmo_ferr",  n_ferr - f0, 1);
    chk("tmo_valid", n_valid - v0, 0);
    chk("tmo_busy",  busy, 0);
    run_frame("t12", 8'h12, 1'b0, 1'b0, 1'b0);

    run_frame("g_aa", 8'hAA, 1'b0, 1'b0, 1'b1);

    // Reset pulse in the middle of a frame
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    drive_frame(mk_frame(8'h77, 1'b0, 1'b0), 5, 1'b0);
    nreset = 1'b0;
    wait_cyc(3);
    nreset = 1'b1;
    model_dout = 8'h00;
    wait_cyc(30);
    chk("rmid_valid", n_valid - v0, 0);
    chk("rmid_perr",  n_perr - p0,  0);
    chk("rmid_ferr",  n_ferr - f0,  0);
    chk("rmid_dout",  data_out,     model_dout);
    chk("rmid_busy",  busy,         0);
    run_frame("r3c", 8'h3C, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      r  = int'($urandom_range(0, 5));
      run_frame($sformatf("rnd%0d", i), rb, (r == 3) || (r == 5), (r == 4) || (r == 5), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
